axi_rd_arbiter: RTL and testbench

Two-master, round-robin AXI3 read-channel arbiter that shares one 64-bit HP read port between two frame-streaming read engines, e.g. the main video source and a second overlay source. It sits between the read engines and the PS HP port. It serialises AR requests through a single-entry registered stage, tags the ID with the master index, routes R beats back by that tag, and caps outstanding bursts per master.

---
 rtl/axi_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master round-robin AXI3 read arbiter onto one HP read port
module axi_rd_arbiter #(
   parameter int MAX_OUTS = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        s0_axi_arvalid,
   output logic        s0_axi_arready,
   input  logic [31:0] s0_axi_araddr,
   input  logic [3:0]  s0_axi_arlen,
   input  logic [5:0]  s0_axi_arid,
   output logic        s0_axi_rvalid,
   input  logic        s0_axi_rready,
   output logic        s0_axi_rlast,
   output logic [63:0] s0_axi_rdata,
   output logic [1:0]  s0_axi_rresp,
   output logic [5:0]  s0_axi_rid,
   input  logic        s1_axi_arvalid,
   output logic        s1_axi_arready,
   input  logic [31:0] s1_axi_araddr,
   input  logic [3:0]  s1_axi_arlen,
   input  logic [5:0]  s1_axi_arid,
   output logic        s1_axi_rvalid,
   input  logic        s1_axi_rready,
   output logic        s1_axi_rlast,
   output logic [63:0] s1_axi_rdata,
   output logic [1:0]  s1_axi_rresp,
   output logic [5:0]  s1_axi_rid,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [3:0]  m_axi_arlen,
   output logic [5:0]  m_axi_arid,
   output logic [1:0]  m_axi_arburst,
   output logic [1:0]  m_axi_arlock,
   output logic [2:0]  m_axi_arsize,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arcache,
   output logic [3:0]  m_axi_arqos,
   input  logic        m_axi_rvalid,
   input  logic        m_axi_rlast,
   input  logic [63:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic [5:0]  m_axi_rid,
   output logic        m_axi_rready
);

   localparam logic       S_IDLE  = 1'b0;
   localparam logic       S_ISSUE = 1'b1;
   localparam logic [3:0] MAX     = 4'(MAX_OUTS);

   logic        r_state;
   logic        r_last;
   logic [3:0]  r_outs0;
   logic [3:0]  r_outs1;
   logic [31:0] r_araddr;
   logic [3:0]  r_arlen;
   logic [5:0]  r_arid;

   logic w_elig0, w_elig1, w_gnt0, w_gnt1;
   logic w_sel, w_inc0, w_inc1, w_dec0, w_dec1;
   logic w_unused_arid;

   // The upper ID bit is dropped to make room for the master tag.
   assign w_unused_arid = s0_axi_arid[5] ^ s1_axi_arid[5];

   // Eligibility and round-robin grant; grants are only made from IDLE and
   // are held off while reset is asserted so arready reads 0 in reset.
   assign w_elig0 = s0_axi_arvalid && (r_outs0 < MAX);
   assign w_elig1 = s1_axi_arvalid && (r_outs1 < MAX);
   assign w_gnt0  = rst_ni && (r_state == S_IDLE) && w_elig0 && (!w_elig1 || r_last);
   assign w_gnt1  = rst_ni && (r_state == S_IDLE) && w_elig1 && (!w_elig0 || !r_last);

   assign s0_axi_arready = w_gnt0;
   assign s1_axi_arready = w_gnt1;

   assign m_axi_arvalid = (r_state == S_ISSUE);
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arid    = r_arid;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 2'b00;
   assign m_axi_arsize  = 3'b011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arqos   = 4'b0000;

   // Zero-latency R routing by the master tag carried in the ID LSB.
   assign w_sel         = m_axi_rid[0];
   assign s0_axi_rvalid = m_axi_rvalid && !w_sel;
   assign s1_axi_rvalid = m_axi_rvalid && w_sel;
   assign m_axi_rready  = w_sel ? s1_axi_rready : s0_axi_rready;
   assign s0_axi_rdata  = m_axi_rdata;
   assign s1_axi_rdata  = m_axi_rdata;
   assign s0_axi_rresp  = m_axi_rresp;
   assign s1_axi_rresp  = m_axi_rresp;
   assign s0_axi_rlast  = m_axi_rlast;
   assign s1_axi_rlast  = m_axi_rlast;
   assign s0_axi_rid    = {1'b0, m_axi_rid[5:1]};
   assign s1_axi_rid    = {1'b0, m_axi_rid[5:1]};

   // A burst counts as outstanding from the downstream AR handshake until its last beat.
   assign w_inc0 = (r_state == S_ISSUE) && m_axi_arready && !r_arid[0];
   assign w_inc1 = (r_state == S_ISSUE) && m_axi_arready && r_arid[0];
   assign w_dec0 = m_axi_rvalid && m_axi_rready && m_axi_rlast && !w_sel;
   assign w_dec1 = m_axi_rvalid && m_axi_rready && m_axi_rlast && w_sel;

   // AR stage: latch the granted request in IDLE, hold it in ISSUE until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_araddr <= '0;
         r_arlen  <= '0;
         r_arid   <= '0;
      end else if (w_gnt0) begin
         r_state  <= S_ISSUE;
         r_last   <= 1'b0;
         r_araddr <= s0_axi_araddr;
         r_arlen  <= s0_axi_arlen;
         r_arid   <= {s0_axi_arid[4:0], 1'b0};
      end else if (w_gnt1) begin
         r_state  <= S_ISSUE;
         r_last   <= 1'b1;
         r_araddr <= s1_axi_araddr;
         r_arlen  <= s1_axi_arlen;
         r_arid   <= {s1_axi_arid[4:0], 1'b1};
      end else if ((r_state == S_ISSUE) && m_axi_arready) begin
         r_state  <= S_IDLE;
      end
   end

   // Master 0 outstanding count; simultaneous inc/dec cancel, a stray decrement at 0 is ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_outs0 <= '0;
      else if (w_inc0 && !w_dec0)
         r_outs0 <= r_outs0 + 4'd1;
      else if (w_dec0 && !w_inc0 && (r_outs0 != 4'd0))
         r_outs0 <= r_outs0 - 4'd1;
   end

   // Master 1 outstanding count; same rules as master 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_outs1 <= '0;
      else if (w_inc1 && !w_dec1)
         r_outs1 <= r_outs1 + 4'd1;
      else if (w_dec1 && !w_inc1 && (r_outs1 != 4'd0))
         r_outs1 <= r_outs1 - 4'd1;
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready, s0_axi_rlast;
   logic [31:0] s0_axi_araddr;
   logic [3:0]  s0_axi_arlen;
   logic [5:0]  s0_axi_arid, s0_axi_rid;
   logic [63:0] s0_axi_rdata;
   logic [1:0]  s0_axi_rresp;
   logic        s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready, s1_axi_rlast;
   logic [31:0] s1_axi_araddr;
   logic [3:0]  s1_axi_arlen;
   logic [5:0]  s1_axi_arid, s1_axi_rid;
   logic [63:0] s1_axi_rdata;
   logic [1:0]  s1_axi_rresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [3:0]  m_axi_arlen;
   logic [5:0]  m_axi_arid;
   logic [1:0]  m_axi_arburst, m_axi_arlock;
   logic [2:0]  m_axi_arsize, m_axi_arprot;
   logic [3:0]  m_axi_arcache, m_axi_arqos;
   logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic [5:0]  m_axi_rid;

   int n_assert = 0;
   int n_fail   = 0;

   axi_rd_arbiter #(.MAX_OUTS(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
      .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arid(s0_axi_arid),
      .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready), .s0_axi_rlast(s0_axi_rlast),
      .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rid(s0_axi_rid),
      .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
      .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arid(s1_axi_arid),
      .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready), .s1_axi_rlast(s1_axi_rlast),
      .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rid(s1_axi_rid),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arsize(m_axi_arsize),
      .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache), .m_axi_arqos(m_axi_arqos),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rready(m_axi_rready)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      rst_ni = 1'b0;
      tick;
      tick;
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni = 1'b0;
      s0_axi_arvalid = 0; s0_axi_araddr = 32'h0000_1000; s0_axi_arlen = 4'd3; s0_axi_arid = 6'h23;
      s1_axi_arvalid = 0; s1_axi_araddr = 32'h2000_0000; s1_axi_arlen = 4'd15; s1_axi_arid = 6'h05;
      s0_axi_rready = 0; s1_axi_rready = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
      m_axi_rresp = 2'b00; m_axi_rid = '0;
      tick;
      tick;

      // Reset state
      chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_s0_arready", 64'(s0_axi_arready), 64'd0);
      chk("rst_s1_arready", 64'(s1_axi_arready), 64'd0);
      chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
      chk("rst_arid", 64'(m_axi_arid), 64'd0);
      chk("rst_outs0", 64'(dut.r_outs0), 64'd0);
      chk("rst_arburst", 64'(m_axi_arburst), 64'd1);
      chk("rst_arcache", 64'(m_axi_arcache), 64'd3);
      chk("rst_arsize", 64'(m_axi_arsize), 64'd3);
      rst_ni = 1'b1;

      // Both masters streaming: grants alternate starting with master 0, stop at 4 each
      s0_axi_arvalid = 1; s1_axi_arvalid = 1; m_axi_arready = 1;
      for (int g = 0; g < 8; g++) begin
         #1;
         chk("rr_s0_arready", 64'(s0_axi_arready), 64'((g % 2) == 0));
         chk("rr_s1_arready", 64'(s1_axi_arready), 64'((g % 2) == 1));
         tick;
         chk("rr_m_arvalid", 64'(m_axi_arvalid), 64'd1);
         chk("rr_m_arid", 64'(m_axi_arid), ((g % 2) == 0) ? 64'h06 : 64'h0B);
         chk("rr_no_grant_in_issue", 64'(s0_axi_arready | s1_axi_arready), 64'd0);
         tick;
      end
      chk("rr_outs0_full", 64'(dut.r_outs0), 64'd4);
      chk("rr_outs1_full", 64'(dut.r_outs1), 64'd4);
      tick;
      chk("rr_stop_s0", 64'(s0_axi_arready), 64'd0);
      chk("rr_stop_s1", 64'(s1_axi_arready), 64'd0);
      chk("rr_stop_arvalid", 64'(m_axi_arvalid), 64'd0);

      // Single request from master 1
      s0_axi_arvalid = 0; s1_axi_arvalid = 0; m_axi_arready = 0;
      do_reset;
      s1_axi_arvalid = 1;
      #1;
      chk("single_s1_arready", 64'(s1_axi_arready), 64'd1);
      chk("single_s0_arready", 64'(s0_axi_arready), 64'd0);
      chk("single_arvalid_pre", 64'(m_axi_arvalid), 64'd0);
      tick;
      s1_axi_arvalid = 0; s1_axi_araddr = 32'hDEAD_BEEF; s1_axi_arlen = 4'd1;
      s0_axi_arvalid = 1;
      chk("single_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("single_araddr", 64'(m_axi_araddr), 64'h2000_0000);
      chk("single_arlen", 64'(m_axi_arlen), 64'd15);
      chk("single_arid", 64'(m_axi_arid), 64'h0B);

      // Downstream stall for 10 cycles: request held, no new grants
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("stall_arvalid", 64'(m_axi_arvalid), 64'd1);
         chk("stall_araddr", 64'(m_axi_araddr), 64'h2000_0000);
         chk("stall_arid", 64'(m_axi_arid), 64'h0B);
         chk("stall_arready", 64'(s0_axi_arready | s1_axi_arready), 64'd0);
         tick;
      end
      s0_axi_arvalid = 0; m_axi_arready = 1;
      tick;
      m_axi_arready = 0;
      chk("stall_done_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("stall_outs1", 64'(dut.r_outs1), 64'd1);

      // R routing: 16 beats tagged for master 1
      m_axi_rvalid = 1; m_axi_rid = 6'b001011; s1_axi_rready = 1; s0_axi_rready = 0;
      for (int b = 0; b < 16; b++) begin
         m_axi_rdata = {32'hA5A5_0000 + 32'(b), 32'h1234_5678};
         m_axi_rlast = (b == 15);
         #1;
         chk("r_s1_rvalid", 64'(s1_axi_rvalid), 64'd1);
         chk("r_s0_rvalid", 64'(s0_axi_rvalid), 64'd0);
         chk("r_s1_rid", 64'(s1_axi_rid), 64'd5);
         chk("r_s1_rdata", s1_axi_rdata, {32'hA5A5_0000 + 32'(b), 32'h1234_5678});
         chk("r_m_rready", 64'(m_axi_rready), 64'd1);
         chk("r_s1_rlast", 64'(s1_axi_rlast), 64'(b == 15));
         chk("r_outs1_hold", 64'(dut.r_outs1), 64'd1);
         tick;
      end
      m_axi_rvalid = 0; m_axi_rlast = 0;
      chk("r_outs1_dec", 64'(dut.r_outs1), 64'd0);
      s1_axi_rready = 0; m_axi_rvalid = 1;
      #1;
      chk("r_backpressure", 64'(m_axi_rready), 64'd0);
      m_axi_rvalid = 0;

      // Simultaneous AR acceptance and rlast for master 0
      do_reset;
      s0_axi_arvalid = 1; m_axi_arready = 1;
      for (int k = 0; k < 6; k++) tick;
      chk("sim_outs0_3", 64'(dut.r_outs0), 64'd3);
      tick;
      m_axi_rvalid = 1; m_axi_rid = 6'b000000; m_axi_rlast = 1; s0_axi_rready = 1;
      tick;
      m_axi_rvalid = 0;
      chk("sim_outs0_unchanged", 64'(dut.r_outs0), 64'd3);
      chk("sim_s0_eligible", 64'(s0_axi_arready), 64'd1);
      tick;
      tick;
      chk("sim_outs0_4", 64'(dut.r_outs0), 64'd4);
      chk("sim_blocked", 64'(s0_axi_arready), 64'd0);
      tick;
      chk("sim_blocked2", 64'(s0_axi_arready), 64'd0);
      m_axi_rvalid = 1;
      #1;
      chk("sim_blocked_on_rlast", 64'(s0_axi_arready), 64'd0);
      tick;
      m_axi_rvalid = 0;
      #1;
      chk("sim_outs0_after_rlast", 64'(dut.r_outs0), 64'd3);
      chk("sim_reeligible", 64'(s0_axi_arready), 64'd1);
      m_axi_rlast = 0; s0_axi_rready = 0;

      // Reset while in ISSUE with two bursts outstanding for master 0
      s0_axi_arvalid = 0;
      do_reset;
      s0_axi_arvalid = 1; m_axi_arready = 1;
      for (int k = 0; k < 4; k++) tick;
      m_axi_arready = 0;
      tick;
      chk("rstmid_arvalid_pre", 64'(m_axi_arvalid), 64'd1);
      chk("rstmid_outs0_pre", 64'(dut.r_outs0), 64'd2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rstmid_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rstmid_outs0", 64'(dut.r_outs0), 64'd0);
      chk("rstmid_araddr", 64'(m_axi_araddr), 64'd0);
      s1_axi_arvalid = 1;
      #1;
      chk("rstmid_no_grant_in_reset", 64'(s0_axi_arready | s1_axi_arready), 64'd0);
      rst_ni = 1'b1;
      #1;
      chk("rstmid_tie_s0", 64'(s0_axi_arready), 64'd1);
      chk("rstmid_tie_s1", 64'(s1_axi_arready), 64'd0);
      tick;
      chk("rstmid_arid", 64'(m_axi_arid), 64'h06);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
